// File: rtl/fetch_pc_unit_if.sv
// Signal bundle between the fetch/PC stage, instruction memory and the decode-side core.
// master = fetch_pc_unit, slave = memory/core environment.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        advance;
  logic        branch_taken;
  logic [31:0] ImmExt;
  logic        misalign_err;
  logic [31:0] instr_count;

  modport master (
    output imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, misalign_err, instr_count,
    input  imem_ready, imem_rdata, advance, branch_taken, ImmExt
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, misalign_err, instr_count,
    output imem_ready, imem_rdata, advance, branch_taken, ImmExt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch stage: fetches a word, holds it for decode until
// accepted, then steps to PC+4 or PC+ImmExt, halting on a misaligned target.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  fetch_pc_unit_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_err_q, misalign_err_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] next_pc_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= NOP_INSTR;
      instr_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
      instr_count_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      misalign_err_q <= misalign_err_d;
      instr_count_q  <= instr_count_d;
    end
  end

  // Next-PC candidate; branch_taken only matters when the core advances
  always_comb begin
    if (bus.branch_taken) begin
      next_pc_s = pc_q + bus.ImmExt;
    end else begin
      next_pc_s = pc_q + 32'd4;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    misalign_err_d = misalign_err_q;
    instr_count_d  = instr_count_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ready) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (bus.advance) begin
          instr_count_d = instr_count_q + 32'd1;
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (next_pc_s[1:0] == 2'b00) begin
            pc_d    = next_pc_s;
            state_d = FETCH;
          end else begin
            misalign_err_d = 1'b1;
            state_d        = HALT;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      HALT: begin
        instr_valid_d = 1'b0;
        instr_d       = NOP_INSTR;
        state_d       = HALT;
      end
      default: begin
        state_d       = HALT;
        instr_valid_d = 1'b0;
        instr_d       = NOP_INSTR;
      end
    endcase
  end

  // Request and address are combinational so reset drops them immediately
  always_comb begin
    bus.imem_req     = (state_q == FETCH);
    bus.imem_addr    = pc_q;
    bus.pc_plus4     = pc_q + 32'd4;
    bus.instr        = instr_q;
    bus.pc           = pc_q;
    bus.instr_valid  = instr_valid_q;
    bus.misalign_err = misalign_err_q;
    bus.instr_count  = instr_count_q;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a per-cycle vector table plus short sequences for
// wait states, misalignment halt, PC wrap and an asynchronous reset pulse mid-fetch.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'h0000_0093;
  localparam logic [31:0] IB  = 32'h00A0_0113;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        adv;
    logic        br;
    logic [31:0] imm;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
    logic        e_err;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vq[$];

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic ready, input logic [31:0] rdata, input logic adv, input logic br,
                     input logic [31:0] imm, input logic e_req, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_cnt,
                     input logic e_err);
    vec_t v;
    v.ready = ready; v.rdata = rdata; v.adv = adv; v.br = br; v.imm = imm;
    v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_cnt = e_cnt; v.e_err = e_err;
    vq.push_back(v);
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs, then step one clock.
  task automatic apply_row(input vec_t v, input int idx);
    bus.imem_ready   = v.ready;
    bus.imem_rdata   = v.rdata;
    bus.advance      = v.adv;
    bus.branch_taken = v.br;
    bus.ImmExt       = v.imm;
    #1;
    chk("imem_req",     idx, {31'd0, bus.imem_req},     {31'd0, v.e_req});
    chk("imem_addr",    idx, bus.imem_addr,             v.e_pc);
    chk("instr_valid",  idx, {31'd0, bus.instr_valid},  {31'd0, v.e_valid});
    chk("pc",           idx, bus.pc,                    v.e_pc);
    chk("pc_plus4",     idx, bus.pc_plus4,              v.e_pc + 32'd4);
    chk("instr",        idx, bus.instr,                 v.e_instr);
    chk("instr_count",  idx, bus.instr_count,           v.e_cnt);
    chk("misalign_err", idx, {31'd0, bus.misalign_err}, {31'd0, v.e_err});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_queue(input int base);
    for (int i = 0; i < vq.size(); i++) apply_row(vq[i], base + i);
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b1;
    bus.imem_ready   = 1'b0;
    bus.imem_rdata   = 32'd0;
    bus.advance      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ImmExt       = 32'd0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0; bus.advance = 1'b0;
    bus.branch_taken = 1'b0; bus.ImmExt = 32'd0;

    // Main table: sequential fetch, branches, stall, zero-offset refetch, ignored inputs
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,          1'b0, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b1, IA,           1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b1, IA,           1'b1, 1'b0, 32'd0,          1'b0, 1'b1, 32'h00, IA,  32'd0, 1'b0);
    add(1'b1, IA,           1'b1, 1'b0, 32'd0,          1'b1, 1'b0, 32'h04, NOP, 32'd1, 1'b0);
    add(1'b1, IA,           1'b1, 1'b0, 32'd0,          1'b0, 1'b1, 32'h04, IA,  32'd1, 1'b0);
    add(1'b1, IA,           1'b1, 1'b0, 32'd0,          1'b1, 1'b0, 32'h08, NOP, 32'd2, 1'b0);
    add(1'b1, IA,           1'b1, 1'b0, 32'd0,          1'b0, 1'b1, 32'h08, IA,  32'd2, 1'b0);
    add(1'b1, IA,           1'b1, 1'b0, 32'd0,          1'b1, 1'b0, 32'h0C, NOP, 32'd3, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,          1'b0, 1'b1, 32'h0C, IA,  32'd3, 1'b0);
    add(1'b1, IA,           1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h10, NOP, 32'd4, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF_FFF8,  1'b0, 1'b1, 32'h10, IA,  32'd4, 1'b0);
    add(1'b1, IB,           1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h08, NOP, 32'd5, 1'b0);
    for (int s = 0; s < 4; s++)
      add(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd4,      1'b0, 1'b1, 32'h08, IB,  32'd5, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b1, 32'h0000_0008,  1'b0, 1'b1, 32'h08, IB,  32'd5, 1'b0);
    add(1'b1, IA,           1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h10, NOP, 32'd6, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b1, 32'h0000_0020,  1'b0, 1'b1, 32'h10, IA,  32'd6, 1'b0);
    add(1'b1, IA,           1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h30, NOP, 32'd7, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b1, 32'd0,          1'b0, 1'b1, 32'h30, IA,  32'd7, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b1, 32'd4,          1'b1, 1'b0, 32'h30, NOP, 32'd8, 1'b0);
    add(1'b1, IA,           1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h30, NOP, 32'd8, 1'b0);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,          1'b0, 1'b1, 32'h30, IA,  32'd8, 1'b0);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'h34, NOP, 32'd9, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_queue(0);

    // Wait states: five idle-ready cycles in FETCH at pc 0
    do_reset();
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    for (int w = 0; w < 5; w++)
      add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b1, IB,    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h00, IB,  32'd0, 1'b0);
    run_queue(100);

    // Misaligned branch target halts with pc held until reset
    do_reset();
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b1, IA,    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 32'h00, IA,  32'd0, 1'b0);
    add(1'b1, IA,    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h04, NOP, 32'd1, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1, 32'h04, IA,  32'd1, 1'b0);
    for (int h = 0; h < 3; h++)
      add(1'b1, IB,  1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h04, NOP, 32'd2, 1'b1);
    run_queue(200);

    // Backward branch to the top of the address space, then sequential wrap to 0
    do_reset();
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_0000, NOP, 32'd0, 1'b0);
    add(1'b1, IA,    1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 32'h0000_0000, NOP, 32'd0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0000, IA,  32'd0, 1'b0);
    add(1'b1, IB,    1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 32'hFFFF_FFFC, NOP, 32'd1, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'hFFFF_FFFC, IB,  32'd1, 1'b0);
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 32'h0000_0000, NOP, 32'd2, 1'b0);
    run_queue(300);

    // Asynchronous reset pulse between clock edges while a fetch is outstanding
    do_reset();
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b1, IA,    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h00, IA,  32'd0, 1'b0);
    run_queue(400);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("pre_reset_req", 410, {31'd0, bus.imem_req}, 32'd1);
    chk("pre_reset_pc",  410, bus.pc,               32'h0000_0004);
    #1;
    reset = 1'b1;
    #1;
    chk("async_req",   411, {31'd0, bus.imem_req},    32'd0);
    chk("async_pc",    411, bus.pc,                   32'h0000_0000);
    chk("async_count", 411, bus.instr_count,          32'd0);
    chk("async_valid", 411, {31'd0, bus.instr_valid}, 32'd0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    add(1'b1, IA,    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00, NOP, 32'd0, 1'b0);
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h00, IA,  32'd0, 1'b0);
    run_queue(420);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
